npc_unit: RTL

Parametrised next-PC generator for the multicycle core. It sits between EXU/WBU and IFU.
- Accepts one resolved instruction outcome per handshake.
- Selects the next PC by fixed priority and checks target alignment.
- Holds the result under a valid/ready handshake until IFU takes it.
- Supersedes the single-state DNPC register with a back-pressured handshake, a boot-vector issue and misaligned-target trapping.

---
 rtl/npc_pkg.sv | 23 ++
 rtl/npc_select.sv | 44 ++++
 rtl/npc_unit.sv | 89 ++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared types and constants for the next-PC generator
package npc_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SRC_RESET    = 3'd0,
        SRC_SEQ      = 3'd1,
        SRC_BRANCH   = 3'd2,
        SRC_JUMP     = 3'd3,
        SRC_MRET     = 3'd4,
        SRC_TRAP     = 3'd5,
        SRC_MISALIGN = 3'd6
    } pc_src_t;

    // mtvec in direct mode: the two mode bits are not part of the address
    localparam logic [63:0] TVEC_MASK = ~64'h3;

endpackage

// File: rtl/npc_select.sv
// npc_select: priority mux over retired-instruction outcomes plus target alignment check
module npc_select
    import npc_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int IALIGN      = 2,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic            is_ecall,
    input  logic            is_mret,
    input  logic            jump,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] snpc,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] target,
    output logic [XLEN-1:0] cand,
    output pc_src_t         src,
    output logic            misalign
);

    logic [XLEN-1:0] tvec;
    logic [XLEN-1:0] jtgt;
    logic [XLEN-1:0] base_tgt;
    pc_src_t         base_src;
    logic            checked;

    always_comb begin
        tvec     = mtvec & TVEC_MASK[XLEN-1:0];
        jtgt     = jump_target & ~{{(XLEN-1){1'b0}}, 1'b1};
        // only control-flow targets can be misaligned; snpc and trap vectors are trusted
        checked  = !is_ecall && (is_mret || jump || branch_taken);
        cand     = is_mret ? mepc : jump ? jtgt : branch_target;
        base_tgt = is_ecall ? tvec : checked ? cand : snpc;
        base_src = is_ecall ? SRC_TRAP : is_mret ? SRC_MRET : jump ? SRC_JUMP :
                   branch_taken ? SRC_BRANCH : SRC_SEQ;
        misalign = ALIGN_CHECK && checked && (|cand[IALIGN-1:0]);
        target   = misalign ? tvec : base_tgt;
        src      = misalign ? SRC_MISALIGN : base_src;
    end

endmodule

// File: rtl/npc_unit.sv
// npc_unit: next-PC generator between EXU/WBU and IFU with boot vector issue,
// valid/ready hand-off and misaligned-target trapping
module npc_unit
    import npc_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
    parameter int              IALIGN      = 2,
    parameter bit              ALIGN_CHECK = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_ecall,
    input  logic            is_mret,
    input  logic            jump,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] branch_target,
    input  logic [XLEN-1:0] snpc,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc,
    output pc_src_t         pc_src,
    output logic            misalign_valid,
    output logic [XLEN-1:0] misalign_addr
);

    state_t          state, state_n;
    logic            accept;
    logic [XLEN-1:0] sel_target, sel_cand;
    pc_src_t         sel_src;
    logic            sel_mis;

    npc_select #(
        .XLEN(XLEN),
        .IALIGN(IALIGN),
        .ALIGN_CHECK(ALIGN_CHECK)
    ) u_select (
        .is_ecall(is_ecall),
        .is_mret(is_mret),
        .jump(jump),
        .branch_taken(branch_taken),
        .jump_target(jump_target),
        .branch_target(branch_target),
        .snpc(snpc),
        .mtvec(mtvec),
        .mepc(mepc),
        .target(sel_target),
        .cand(sel_cand),
        .src(sel_src),
        .misalign(sel_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_BOOT;
        else     state <= state_n;
    end

    // handshake outputs depend on state only, so IFU never sees a combinational path from upstream
    always_comb begin
        accept    = (state == S_WAIT) && in_valid;
        out_valid = (state == S_BOOT) || (state == S_OUT);
        in_ready  = (state == S_WAIT);
        state_n   = (state == S_BOOT && out_ready) ? S_WAIT :
                    accept                         ? S_OUT  :
                    (state == S_OUT && out_ready)  ? S_WAIT : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            pc_src         <= SRC_RESET;
            misalign_valid <= 1'b0;
            misalign_addr  <= '0;
        end else begin
            misalign_valid <= accept && sel_mis;
            if (accept) begin
                pc     <= sel_target;
                pc_src <= sel_src;
            end
            if (accept && sel_mis) misalign_addr <= sel_cand;
        end
    end

endmodule
